// File: rtl/memory_tester_if.sv
// Memory request/response bundle shared by memory_tester and the memory it
// exercises, plus the shared width type and data-path width.
//   master (tester) : drives mem_addr, mem_wwidth, mem_wenable, mem_wdata;
//                     receives mem_rdata
//   slave  (memory) : the mirror image
package memory_tester_pkg;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        write_byte     = 2'd0,
        write_halfword = 2'd1,
        write_word     = 2'd2
    } write_width_t;
endpackage

interface memory_tester_if;
    import memory_tester_pkg::*;

    logic [XLEN-1:0] mem_addr;
    write_width_t    mem_wwidth;
    logic            mem_wenable;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_addr, mem_wwidth, mem_wenable, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wwidth, mem_wenable, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/memory_tester.sv
// memory_tester: fills an address window with a seed-derived pattern, reads it
// back and reports pass/fail, a saturating mismatch count and the address of
// the first mismatch.
// Ports:
//   clk, reset            clock, async active-high reset
//   start, abort          launch a sweep / drop back to IDLE
//   mode, seed            element width and pattern seed (latched on start)
//   busy, done, pass      sweep status (all registered)
//   err_count             mismatches this sweep, saturating
//   first_err_addr        byte address of the first mismatch, 0 if none
//   mem                   memory request/response bundle (master side)
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | waiting for start, outputs held
// FILL     | one write per cycle, element idx
// RD_ISSUE | read address for element idx presented
// RD_WAIT  | waiting out the remaining read latency
// CHECK    | read data valid, compare element idx
// DONE     | sweep finished, results held until next start
module memory_tester
    import memory_tester_pkg::*;
#(
    parameter logic [XLEN-1:0] BASE_ADDR    = '0,
    parameter int              DEPTH        = 64,
    parameter int              READ_LATENCY = 1,
    parameter int              ERR_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  write_width_t      mode,
    input  logic [7:0]        seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [XLEN-1:0]   first_err_addr,
    memory_tester_if.master   mem
);

    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WAIT_W    = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
    localparam int WAIT_INIT = (READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE, FILL, RD_ISSUE, RD_WAIT, CHECK, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d, idx_next;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    write_width_t        mode_q, mode_d;
    logic [7:0]          seed_q, seed_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [XLEN-1:0]     first_q, first_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic                wen_q, wen_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                last, do_check, mismatch;

    // Unused width encoding is treated as byte everywhere so address step and
    // compare mask stay consistent.
    function automatic logic [XLEN-1:0] addr_of(logic [IDX_W-1:0] idx, write_width_t w);
        logic [XLEN-1:0] off;
        off = XLEN'(idx);
        case (w)
            write_halfword: off = off << 1;
            write_word:     off = off << 2;
            default:        off = off;
        endcase
        return BASE_ADDR + off;
    endfunction

    function automatic logic [XLEN-1:0] width_mask(write_width_t w);
        case (w)
            write_halfword: return XLEN'(16'hFFFF);
            write_word:     return '1;
            default:        return XLEN'(8'hFF);
        endcase
    endfunction

    function automatic logic [XLEN-1:0] pattern(logic [IDX_W-1:0] idx, logic [7:0] s,
                                                write_width_t w);
        return (XLEN'(s) + XLEN'(idx)) & width_mask(w);
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wait_d   = wait_q;
        mode_d   = mode_q;
        seed_d   = seed_q;
        err_d    = err_q;
        first_d  = first_q;
        addr_d   = addr_q;
        wen_d    = 1'b0;
        wdata_d  = '0;
        idx_next = idx_q + 1'b1;
        last     = (idx_q == IDX_LAST);
        // With combinational read the issue cycle doubles as the compare cycle.
        do_check = (state_q == CHECK) || ((state_q == RD_ISSUE) && (READ_LATENCY == 0));
        mismatch = ((mem.mem_rdata & width_mask(mode_q)) != pattern(idx_q, seed_q, mode_q));

        case (state_q)
            IDLE, DONE: begin
                if (start && !abort) begin
                    state_d = FILL;
                    idx_d   = '0;
                    mode_d  = mode;
                    seed_d  = seed;
                    err_d   = '0;
                    first_d = '0;
                    addr_d  = addr_of('0, mode);
                    wen_d   = 1'b1;
                    wdata_d = pattern('0, seed, mode);
                end
            end
            FILL: begin
                if (last) begin
                    state_d = RD_ISSUE;
                    idx_d   = '0;
                    addr_d  = addr_of('0, mode_q);
                end else begin
                    idx_d   = idx_next;
                    addr_d  = addr_of(idx_next, mode_q);
                    wen_d   = 1'b1;
                    wdata_d = pattern(idx_next, seed_q, mode_q);
                end
            end
            RD_ISSUE: begin
                if (READ_LATENCY == 1) begin
                    state_d = CHECK;
                end else if (READ_LATENCY >= 2) begin
                    state_d = RD_WAIT;
                    wait_d  = WAIT_W'(WAIT_INIT);
                end
            end
            RD_WAIT: begin
                if (wait_q == '0) state_d = CHECK;
                else              wait_d  = wait_q - 1'b1;
            end
            default: ;
        endcase

        if (do_check) begin
            if (mismatch) begin
                if (err_q != '1) err_d = err_q + 1'b1;
                if (err_q == '0) first_d = addr_of(idx_q, mode_q);
            end
            if (last) begin
                state_d = DONE;
            end else begin
                state_d = RD_ISSUE;
                idx_d   = idx_next;
                addr_d  = addr_of(idx_next, mode_q);
            end
        end

        // Abort wins over everything in a busy state; partial counts are kept.
        if (abort && (state_q != IDLE) && (state_q != DONE)) begin
            state_d = IDLE;
            wen_d   = 1'b0;
            wdata_d = '0;
            err_d   = err_q;
            first_d = first_q;
            idx_d   = idx_q;
            addr_d  = addr_q;
        end

        busy_d = (state_d == FILL) || (state_d == RD_ISSUE) ||
                 (state_d == RD_WAIT) || (state_d == CHECK);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            mode_q  <= write_byte;
            seed_q  <= '0;
            err_q   <= '0;
            first_q <= '0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            mode_q  <= mode_d;
            seed_q  <= seed_d;
            err_q   <= err_d;
            first_q <= first_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_addr  = first_q;
    assign mem.mem_addr    = addr_q;
    assign mem.mem_wwidth  = mode_q;
    assign mem.mem_wenable = wen_q;
    assign mem.mem_wdata   = wdata_q;

endmodule
